// File: rtl/uart_mmio_ctrl_if.sv
// CPU peripheral-select bus between the core and uart_mmio_ctrl.
// The CPU side uses the master modport; the peripheral uses the slave modport.
interface uart_mmio_ctrl_if;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;

    logic              sel;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (output sel, addr, we, wdata, input rdata);
    modport slave  (input sel, addr, we, wdata, output rdata);
endinterface

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: TX/RX byte FIFOs, uart_tx start/done sequencing, LED/digit and status regs.
// Define UART_IRQ_EN to add the irq output and the IRQEN register at offset 0x24.
module uart_mmio_ctrl #(
    parameter int unsigned TX_DEPTH = 4,
    parameter int unsigned RX_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    uart_mmio_ctrl_if.slave bus,
    output logic [7:0]      leds,
    output logic [3:0]      ans,
    output logic            tx_start,
    output logic [7:0]      tx_byte,
    input  logic            tx_active,
    input  logic            tx_done,
    input  logic            rx_dv,
    input  logic [7:0]      rx_byte
`ifdef UART_IRQ_EN
    ,
    output logic            irq
`endif
);
    localparam int unsigned TX_AW = $clog2(TX_DEPTH);
    localparam int unsigned TX_CW = TX_AW + 1;
    localparam int unsigned RX_AW = $clog2(RX_DEPTH);
    localparam int unsigned RX_CW = RX_AW + 1;

    localparam logic [7:0] ADDR_LEDS   = 8'h10;
    localparam logic [7:0] ADDR_TXDATA = 8'h18;
    localparam logic [7:0] ADDR_RXDATA = 8'h1C;
    localparam logic [7:0] ADDR_STATUS = 8'h20;
`ifdef UART_IRQ_EN
    localparam logic [7:0] ADDR_IRQEN  = 8'h24;
`endif

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state;

    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [TX_CW-1:0] tx_count;
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [RX_CW-1:0] rx_count;
    logic             tx_ovf, rx_ovr;
    logic [31:0]      rd_val;

    // Bus decode
    logic rd_acc, wr_acc, tx_wr, rx_rd, stat_rd, leds_wr;
    assign rd_acc  = bus.sel && !bus.we;
    assign wr_acc  = bus.sel && bus.we;
    assign tx_wr   = wr_acc && (bus.addr == ADDR_TXDATA);
    assign leds_wr = wr_acc && (bus.addr == ADDR_LEDS);
    assign rx_rd   = rd_acc && (bus.addr == ADDR_RXDATA);
    assign stat_rd = rd_acc && (bus.addr == ADDR_STATUS);

    logic tx_full, tx_empty, rx_nonempty, tx_busy;
    assign tx_full     = (tx_count == TX_CW'(TX_DEPTH));
    assign tx_empty    = (tx_count == '0);
    assign rx_nonempty = (rx_count != '0);
    assign tx_busy     = (state != IDLE) || tx_active;

    // A full FIFO still takes a write or a byte when the same cycle frees a slot.
    logic tx_pop, tx_push, tx_ovf_evt, rx_pop, rx_push, rx_ovr_evt;
    assign tx_pop     = (state == IDLE) && !tx_empty && !tx_active;
    assign tx_push    = tx_wr && (!tx_full || tx_pop);
    assign tx_ovf_evt = tx_wr && !tx_push;
    assign rx_pop     = rx_rd && rx_nonempty;
    assign rx_push    = rx_dv && ((rx_count != RX_CW'(RX_DEPTH)) || rx_pop);
    assign rx_ovr_evt = rx_dv && !rx_push;

    logic unused_wdata;
    assign unused_wdata = ^bus.wdata[31:12];

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= bus.wdata[7:0];
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_byte;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + TX_CW'(1);
                2'b01:   tx_count <= tx_count - TX_CW'(1);
                default: tx_count <= tx_count;
            endcase
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + RX_CW'(1);
                2'b01:   rx_count <= rx_count - RX_CW'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

    // TX sequencer: tx_byte stays at the popped head until the next start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_byte  <= 8'h00;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: if (tx_pop) begin
                    tx_byte  <= tx_mem[tx_rd_ptr];
                    tx_start <= 1'b1;
                    state    <= BUSY;
                end
                BUSY: if (tx_done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_IRQ_EN
    logic [2:0] irqen;
`endif

    always_comb begin
        rd_val = '0;
        case (bus.addr)
            ADDR_LEDS:   rd_val = {20'b0, ans, leds};
            ADDR_RXDATA: if (rx_nonempty) rd_val = {24'b0, rx_mem[rx_rd_ptr]};
            ADDR_STATUS: rd_val = {8'b0, 8'(rx_count), 8'(tx_count), 2'b0, tx_ovf, rx_ovr,
                                   tx_busy, rx_nonempty, tx_empty, tx_full};
`ifdef UART_IRQ_EN
            ADDR_IRQEN:  rd_val = {29'b0, irqen};
`endif
            default:     rd_val = '0;
        endcase
    end

    // Sticky error flags: a new event in the clearing cycle wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rdata <= '0;
            leds      <= '0;
            ans       <= '0;
            tx_ovf    <= 1'b0;
            rx_ovr    <= 1'b0;
        end else begin
            if (rd_acc) bus.rdata <= rd_val;
            if (leds_wr) begin
                leds <= bus.wdata[7:0];
                ans  <= bus.wdata[11:8];
            end
            tx_ovf <= tx_ovf_evt || (tx_ovf && !stat_rd);
            rx_ovr <= rx_ovr_evt || (rx_ovr && !stat_rd);
        end
    end

`ifdef UART_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqen <= '0;
            irq   <= 1'b0;
        end else begin
            if (wr_acc && (bus.addr == ADDR_IRQEN)) irqen <= bus.wdata[2:0];
            irq <= (irqen[0] && rx_nonempty) ||
                   (irqen[1] && tx_empty && (state == IDLE)) ||
                   (irqen[2] && (rx_ovr || tx_ovf));
        end
    end
`endif
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Self-checking bench for uart_mmio_ctrl: directed steps plus randomized RX/LED/TX traffic
// against a queue-based reference model and a behavioural uart_tx responder.
`timescale 1ns/1ps
module tb_uart_mmio_ctrl;
    localparam int unsigned TX_DEPTH = 4;
    localparam int unsigned RX_DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] leds;
    logic [3:0] ans;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx_active;
    logic       tx_done;
    logic       rx_dv;
    logic [7:0] rx_byte;
`ifdef UART_IRQ_EN
    logic       irq;
`endif

    always #5 clk = ~clk;

    uart_mmio_ctrl_if bus ();

    uart_mmio_ctrl #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(bus), .leds(leds), .ans(ans),
        .tx_start(tx_start), .tx_byte(tx_byte), .tx_active(tx_active), .tx_done(tx_done),
        .rx_dv(rx_dv), .rx_byte(rx_byte)
`ifdef UART_IRQ_EN
        , .irq(irq)
`endif
    );

    // Reference model state
    logic [7:0]  tx_pend [$];
    logic [7:0]  rx_q [$];
    bit          m_tx_ovf, m_rx_ovr;
    logic [7:0]  m_leds;
    logic [3:0]  m_ans;
    logic [31:0] m_rdata;
    int          checks, errors;

    // uart_tx responder controls
    bit uart_busy, free_run, ext_busy;
    int hold_tokens, frame_len, tx_starts;
    assign tx_active = uart_busy | ext_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        tx_pend.delete();
        rx_q.delete();
        m_tx_ovf = 0; m_rx_ovr = 0;
        m_leds = '0; m_ans = '0; m_rdata = '0;
    endtask

    function automatic logic [31:0] exp_status(input bit busy);
        logic [31:0] s;
        s = '0;
        s[0]     = (tx_pend.size() == TX_DEPTH);
        s[1]     = (tx_pend.size() == 0);
        s[2]     = (rx_q.size() != 0);
        s[3]     = busy;
        s[4]     = m_rx_ovr;
        s[5]     = m_tx_ovf;
        s[15:8]  = 8'(tx_pend.size());
        s[23:16] = 8'(rx_q.size());
        return s;
    endfunction

    // Bus write: model effects decided before the edge so they precede any FSM pop it enables.
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        if (a == 8'h10) begin m_leds = d[7:0]; m_ans = d[11:8]; end
        if (a == 8'h18) begin
            if (tx_pend.size() < TX_DEPTH) tx_pend.push_back(d[7:0]);
            else m_tx_ovf = 1;
        end
        @(negedge clk);
        bus.sel = 1; bus.we = 1; bus.addr = a; bus.wdata = d;
        @(posedge clk); #1;
        bus.sel = 0; bus.we = 0;
    endtask

    task automatic do_read(input logic [7:0] a, input bit pulse_rx, input logic [7:0] rb,
                           output logic [31:0] d);
        @(negedge clk);
        bus.sel = 1; bus.we = 0; bus.addr = a;
        if (pulse_rx) begin rx_dv = 1; rx_byte = rb; end
        @(posedge clk); #1;
        d = bus.rdata;
        bus.sel = 0; rx_dv = 0;
    endtask

    task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        do_read(a, 0, 8'h00, d);
        m_rdata = exp;
        check(tag, d, exp);
    endtask

    task automatic read_rx(input string tag, input bit pulse_rx, input logic [7:0] rb);
        logic [31:0] exp, d;
        exp = '0;
        if (rx_q.size() > 0) exp = {24'b0, rx_q.pop_front()};
        if (pulse_rx) begin
            if (rx_q.size() < RX_DEPTH) rx_q.push_back(rb);
            else m_rx_ovr = 1;
        end
        do_read(8'h1C, pulse_rx, rb, d);
        m_rdata = exp;
        check(tag, d, exp);
    endtask

    task automatic read_status(input string tag, input bit busy);
        logic [31:0] exp;
        exp = exp_status(busy);
        m_tx_ovf = 0; m_rx_ovr = 0;
        rd_check(tag, 8'h20, exp);
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        if (rx_q.size() < RX_DEPTH) rx_q.push_back(b);
        else m_rx_ovr = 1;
        @(negedge clk);
        rx_dv = 1; rx_byte = b;
        @(posedge clk); #1;
        rx_dv = 0;
    endtask

    task automatic wait_starts(input string tag, input int target);
        int n;
        n = 0;
        while (tx_starts < target && n < 2000) begin @(posedge clk); #1; n++; end
        check(tag, 32'(tx_starts), 32'(target));
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic wait_tx_drain(input string tag);
        int n;
        n = 0;
        while ((tx_pend.size() != 0 || uart_busy) && n < 3000) begin @(posedge clk); #1; n++; end
        check(tag, 32'(n < 3000), 32'd1);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    // Behavioural uart_tx: checks byte order and that no start arrives inside a frame.
    initial begin : uart_tx_model
        int guard;
        tx_done = 0; uart_busy = 0;
        forever begin
            @(posedge clk); #1;
            tx_done = 0;
            if (tx_start === 1'b1 && !reset) begin
                if (tx_pend.size() == 0) check("tx_start_unexpected", 32'(tx_start), 32'd0);
                else check("tx_byte_order", 32'(tx_byte), 32'(tx_pend.pop_front()));
                tx_starts++;
                uart_busy = 1;
                for (int i = 0; i < frame_len; i++) begin
                    @(posedge clk); #1;
                    check("tx_start_spacing", 32'(tx_start), 32'd0);
                end
                guard = 0;
                while (!free_run && hold_tokens == 0 && guard < 5000) begin
                    @(posedge clk); #1; guard++;
                end
                check("uart_hold_bound", 32'(guard < 5000), 32'd1);
                if (hold_tokens > 0) hold_tokens--;
                tx_done = 1; uart_busy = 0;
            end
        end
    end

    initial begin : stimulus
        logic [7:0]  b;
        logic [31:0] d;
        int          n, op, start_base;
        checks = 0; errors = 0;
        bus.sel = 0; bus.we = 0; bus.addr = '0; bus.wdata = '0;
        rx_dv = 0; rx_byte = '0;
        free_run = 0; ext_busy = 0; hold_tokens = 0; frame_len = 6; tx_starts = 0;
        model_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_leds_ans", {20'b0, ans, leds}, 32'h0);
        check("rst_tx_start_byte", {23'b0, tx_start, tx_byte}, 32'h0);
        @(negedge clk) reset = 0;

        // Step 1: reset while BUSY, then the LED register
        wr(8'h18, 32'($urandom_range(0, 255)));
        wait_starts("t1_first_start", 1);
        read_status("t1_status_busy", 1);
        @(negedge clk);
        reset = 1;
        model_reset();
        #2;
        check("t1_async_rdata", bus.rdata, 32'h0);
        check("t1_async_tx", {23'b0, tx_start, tx_byte}, 32'h0);
        check("t1_async_leds", {20'b0, ans, leds}, 32'h0);
        @(negedge clk) reset = 0;
        hold_tokens = 1;
        wait_tx_drain("t1_stray_done");
        check("t1_no_restart", 32'(tx_starts), 32'd1);
        read_status("t1_status_idle", 0);
        wr(8'h10, 32'h0000_0A5C);
        check("t1_leds_ans", {20'b0, ans, leds}, 32'h0000_0A5C);
        rd_check("t1_read_leds", 8'h10, 32'h0000_0A5C);

        // Step 2: three bytes, each start gated by the previous done
        frame_len = 4; ext_busy = 1;
        wr(8'h18, 32'h41); wr(8'h18, 32'h42); wr(8'h18, 32'h43);
        read_status("t2_count3", 1);
        ext_busy = 0;
        wait_starts("t2_start1", 2);
        read_status("t2_count2", 1);
        hold_tokens = 1;
        wait_starts("t2_start2", 3);
        read_status("t2_count1", 1);
        hold_tokens = 1;
        wait_starts("t2_start3", 4);
        read_status("t2_count0", 1);
        hold_tokens = 1;
        wait_tx_drain("t2_drain");
        read_status("t2_idle", 0);

        // Step 3: overflow while BUSY
        frame_len = 5;
        start_base = tx_starts;
        wr(8'h18, 32'($urandom_range(0, 255)));
        wait_starts("t3_start", start_base + 1);
        for (int i = 0; i < 5; i++) wr(8'h18, 32'($urandom_range(0, 255)));
        read_status("t3_overflow", 1);
        read_status("t3_ovf_cleared", 1);
        check("t3_rdata_hold", bus.rdata, m_rdata);
        free_run = 1;
        wait_tx_drain("t3_drain");
        free_run = 0;
        read_status("t3_idle", 0);

        // Step 4: RX overrun and drain
        for (int i = 0; i < 5; i++) rx_pulse(8'(8'h10 + i));
        read_status("t4_overrun", 0);
        for (int i = 0; i < 5; i++) read_rx("t4_rxdata", 0, 8'h00);
        read_status("t4_empty", 0);

        // Step 5: byte arriving on a full FIFO in the same cycle as a pop
        for (int i = 0; i < 4; i++) rx_pulse(8'($urandom));
        read_rx("t5_pop_push", 1, 8'($urandom));
        read_status("t5_no_overrun", 0);
        for (int i = 0; i < 4; i++) read_rx("t5_drain", 0, 8'h00);

`ifdef UART_IRQ_EN
        // Step 6: interrupt on RX data
        wr(8'h24, 32'h1);
        rd_check("t6_irqen", 8'h24, 32'h1);
        check("t6_irq_idle", 32'(irq), 32'd0);
        rx_pulse(8'h77);
        @(posedge clk); #1;
        check("t6_irq_set", 32'(irq), 32'd1);
        read_rx("t6_pop", 0, 8'h00);
        @(posedge clk); #1;
        check("t6_irq_clear", 32'(irq), 32'd0);
        wr(8'h24, 32'h0);
`endif

        // Randomized RX / register traffic with TX idle
        for (int it = 0; it < 160; it++) begin
            op = $urandom_range(0, 7);
            case (op)
                0: rx_pulse(8'($urandom));
                1: read_rx("rnd_rxdata", 0, 8'h00);
                2: read_rx("rnd_rx_pop_push", 1, 8'($urandom));
                3: read_status("rnd_status", 0);
                4: begin
                    wr(8'h10, $urandom);
                    check("rnd_leds_ans", {20'b0, ans, leds}, {20'b0, m_ans, m_leds});
                end
                5: begin
                    case ($urandom_range(0, 5))
                        0: b = 8'h00; 1: b = 8'h14; 2: b = 8'h11;
                        3: b = 8'h21; 4: b = 8'hFF;
`ifdef UART_IRQ_EN
                        default: b = 8'h28;
`else
                        default: b = 8'h24;
`endif
                    endcase
                    rd_check("rnd_unmapped_rd", b, 32'h0);
                end
                6: begin
                    case ($urandom_range(0, 2))
                        0: b = 8'h1C; 1: b = 8'h20; default: b = 8'h30;
                    endcase
                    wr(b, $urandom);
                    check("rnd_ignored_wr_rdata", bus.rdata, m_rdata);
                    check("rnd_ignored_wr_leds", {20'b0, ans, leds}, {20'b0, m_ans, m_leds});
                end
                default: rd_check("rnd_leds_rd", 8'h10, {20'b0, m_ans, m_leds});
            endcase
        end

        // Randomized TX bursts with a free-running uart_tx
        free_run = 1;
        for (int r = 0; r < 6; r++) begin
            frame_len = $urandom_range(2, 8);
            n = $urandom_range(1, TX_DEPTH);
            for (int i = 0; i < n; i++) wr(8'h18, $urandom);
            wait_tx_drain("rnd_tx_drain");
            read_status("rnd_tx_status", 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
